// File: rtl/cpu_axi_bridge.sv
// Bridges the core's SRAM-like fetch and data ports onto a single AXI3 master.
// Define AXI_BRIDGE_RDATA_BUF_EN to register R data/id before returning it to the core.
module cpu_axi_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic {AR_IDLE, AR_SEND} ar_state_t;
  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;

  ar_state_t ar_state, ar_next;
  w_state_t  w_state, w_next;

  logic inst_pend, data_pend, data_is_wr;
  logic rready_q;
  logic aw_done, w_done;
  logic ar_idle, w_idle;
  logic data_rd_win, data_wr_acc, inst_acc;
  logic r_fire;
  logic inst_r_ok, data_r_ok, b_ok;

  assign ar_idle = (ar_state == AR_IDLE);
  assign w_idle  = (w_state == W_IDLE);

  // Data reads take priority over fetches for the shared AR channel.
  assign data_rd_win = ~rst & data_req & ~data_wr & ~data_pend & ar_idle;
  assign inst_acc    = ~rst & inst_req & ar_idle & ~inst_pend & ~data_rd_win;
  assign data_wr_acc = ~rst & data_req & data_wr & w_idle & ~data_pend;

  assign inst_addr_ok = inst_acc;
  assign data_addr_ok = data_rd_win | data_wr_acc;

  assign rready = rready_q;
  assign r_fire = rvalid & rready_q;

`ifdef AXI_BRIDGE_RDATA_BUF_EN
  logic        r_v_q;
  logic [3:0]  r_id_q;
  logic [31:0] r_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v_q    <= 1'b0;
      r_id_q   <= '0;
      r_data_q <= '0;
    end else begin
      r_v_q <= r_fire;
      if (r_fire) begin
        r_id_q   <= rid;
        r_data_q <= rdata;
      end
    end
  end

  assign inst_r_ok  = r_v_q & (r_id_q == 4'd0) & inst_pend;
  assign data_r_ok  = r_v_q & (r_id_q == 4'd1) & data_pend & ~data_is_wr;
  assign inst_rdata = r_data_q;
  assign data_rdata = r_data_q;
`else
  assign inst_r_ok  = r_fire & (rid == 4'd0) & inst_pend;
  assign data_r_ok  = r_fire & (rid == 4'd1) & data_pend & ~data_is_wr;
  assign inst_rdata = rdata;
  assign data_rdata = rdata;
`endif

  assign b_ok         = (w_state == W_RESP) & bvalid;
  assign inst_data_ok = inst_r_ok;
  assign data_data_ok = data_r_ok | b_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_pend  <= 1'b0;
      data_pend  <= 1'b0;
      data_is_wr <= 1'b0;
      rready_q   <= 1'b0;
    end else begin
      rready_q <= 1'b1;
      if (inst_acc)
        inst_pend <= 1'b1;
      else if (inst_r_ok)
        inst_pend <= 1'b0;
      if (data_addr_ok) begin
        data_pend  <= 1'b1;
        data_is_wr <= data_wr;
      end else if (data_data_ok) begin
        data_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      ar_state <= AR_IDLE;
    else
      ar_state <= ar_next;
  end

  always_comb begin
    ar_next = ar_state;
    if (ar_state == AR_IDLE) begin
      if (inst_acc | data_rd_win)
        ar_next = AR_SEND;
    end else if (arready) begin
      ar_next = AR_IDLE;
    end
  end

  assign arvalid = (ar_state == AR_SEND);

  always_ff @(posedge clk) begin
    if (rst) begin
      arid   <= '0;
      araddr <= '0;
      arsize <= '0;
    end else if (data_rd_win) begin
      arid   <= 4'd1;
      araddr <= data_addr;
      arsize <= {1'b0, data_size};
    end else if (inst_acc) begin
      arid   <= 4'd0;
      araddr <= inst_addr;
      arsize <= 3'd2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      w_state <= W_IDLE;
    else
      w_state <= w_next;
  end

  // AW and W retire independently; the done flags only live inside W_SEND.
  always_ff @(posedge clk) begin
    if (rst || w_state != W_SEND) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (awvalid & awready) aw_done <= 1'b1;
      if (wvalid & wready)   w_done  <= 1'b1;
    end
  end

  assign awvalid = (w_state == W_SEND) & ~aw_done;
  assign wvalid  = (w_state == W_SEND) & ~w_done;
  assign bready  = (w_state == W_RESP);

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE: if (data_wr_acc) w_next = W_SEND;
      W_SEND: if ((aw_done | (awvalid & awready)) & (w_done | (wvalid & wready)))
                w_next = W_RESP;
      W_RESP: if (bvalid) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      awaddr <= '0;
      awsize <= '0;
      wdata  <= '0;
      wstrb  <= '0;
    end else if (data_wr_acc) begin
      awaddr <= data_addr;
      awsize <= {1'b0, data_size};
      wdata  <= data_wdata;
      wstrb  <= data_wstrb;
    end
  end

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Bench for cpu_axi_bridge: directed scenarios followed by randomized traffic
// against a transaction-level model (per-source request queues plus an AXI slave).
module tb_cpu_axi_bridge;

`ifdef AXI_BRIDGE_RDATA_BUF_EN
  localparam int RL = 1;
`else
  localparam int RL = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rvalid, rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic        bvalid, bready;

  always #5 clk = ~clk;

  cpu_axi_bridge dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'hC3A5_1E0F;
  endfunction

  typedef struct packed {
    logic [3:0]  id;
    logic [2:0]  size;
    logic [31:0] addr;
  } arx_t;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dreq_t;

  logic [31:0] inst_q[$];
  dreq_t       data_q[$];
  arx_t        ar_q[$];
  arx_t        slv_r[$];
  logic        aw_got, w_got;
  logic        pb_v;
  logic [3:0]  pb_id;
  logic        ar_free, d_free, wr_act, e_rwin;
  logic        e_inst_aok, e_data_aok, e_awvalid, e_wvalid, e_bready;
  logic        eb_v;
  logic [3:0]  eb_id;
  logic        e_inst_ok, e_data_rok, e_b_ok;
  int          idx;

  task automatic idle_inputs();
    inst_req = 0; inst_addr = '0;
    data_req = 0; data_wr = 0; data_size = '0; data_wstrb = '0;
    data_addr = '0; data_wdata = '0;
    arready = 0; rid = '0; rdata = '0; rvalid = 0;
    awready = 0; wready = 0; bvalid = 0;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    inst_req = 1; data_req = 1;
    repeat (3) nxt();
    smp();
    check_eq("reset_ctrl", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok,
                            arvalid, awvalid, wvalid, bready, rready}, '0);
    check_eq("reset_rdata", {inst_rdata, data_rdata}, '0);
    nxt(); rst = 0; idle_inputs();
    nxt();
    smp(); check_eq("rready_up", rready, 1);

    // Single fetch
    nxt(); inst_req = 1; inst_addr = 32'h1C00_0000; arready = 1;
    smp(); check_eq("t1_addr_ok", inst_addr_ok, 1);
    nxt(); inst_req = 0;
    smp(); check_eq("t1_ar", {arvalid, arid, arsize, araddr}, {1'b1, 4'd0, 3'd2, 32'h1C00_0000});
    nxt(); rvalid = 1; rid = 4'd0; rdata = 32'h0280_0C0C;
    for (int k = 2; k <= 4; k++) begin
      smp();
      check_eq("t1_data_ok", inst_data_ok, (k == 2 + RL));
      if (k == 2 + RL) check_eq("t1_rdata", inst_rdata, 32'h0280_0C0C);
      nxt(); rvalid = 0; rdata = '0;
    end

    // Simultaneous reads, then out-of-order R
    inst_req = 1; inst_addr = 32'h100;
    data_req = 1; data_wr = 0; data_addr = 32'h200; data_size = 2'd0;
    smp(); check_eq("t2_acc", {inst_addr_ok, data_addr_ok}, 2'b01);
    nxt(); data_req = 0;
    smp();
    check_eq("t2_ar_data", {arvalid, arid, arsize, araddr}, {1'b1, 4'd1, 3'd0, 32'h200});
    check_eq("t2_inst_wait", inst_addr_ok, 0);
    nxt();
    smp(); check_eq("t2_inst_acc", {arvalid, inst_addr_ok}, 2'b01);
    nxt(); inst_req = 0;
    smp(); check_eq("t2_ar_inst", {arvalid, arid, arsize, araddr}, {1'b1, 4'd0, 3'd2, 32'h100});
    nxt(); arready = 0; rvalid = 1; rid = 4'd1; rdata = 32'hAAAA_5555;
    for (int k = 4; k <= 7; k++) begin
      smp();
      check_eq("t3_data_ok", data_data_ok, (k == 4 + RL));
      check_eq("t3_inst_ok", inst_data_ok, (k == 5 + RL));
      if (k == 4 + RL) check_eq("t3_data_rdata", data_rdata, 32'hAAAA_5555);
      if (k == 5 + RL) check_eq("t3_inst_rdata", inst_rdata, 32'h1234_5678);
      nxt();
      if (k == 4) begin rid = 4'd0; rdata = 32'h1234_5678; end
      else begin rvalid = 0; rdata = '0; end
    end

    // AR back-pressure
    inst_req = 1; inst_addr = 32'h3000; arready = 0;
    smp(); check_eq("t5_acc", inst_addr_ok, 1);
    for (int k = 1; k <= 5; k++) begin
      nxt(); arready = (k == 5);
      smp(); check_eq("t5_ar_hold", {arvalid, araddr, inst_addr_ok}, {1'b1, 32'h3000, 1'b0});
    end
    nxt(); arready = 0; inst_req = 0; rvalid = 1; rid = 4'd0; rdata = 32'hCAFE_F00D;
    for (int k = 6; k <= 7; k++) begin
      smp();
      check_eq("t5_arvalid_low", arvalid, 0);
      check_eq("t5_data_ok", inst_data_ok, (k == 6 + RL));
      if (k == 6 + RL) check_eq("t5_rdata", inst_rdata, 32'hCAFE_F00D);
      nxt(); rvalid = 0; rdata = '0;
    end

    // Write with skewed handshakes; the request is held so the re-accept point is visible
    data_req = 1; data_wr = 1; data_addr = 32'h8000; data_size = 2'd1;
    data_wstrb = 4'h3; data_wdata = 32'h0000_BEEF;
    for (int k = 0; k <= 6; k++) begin
      awready = (k == 1); wready = (k == 3); bvalid = (k == 5);
      smp();
      check_eq("t4_ctrl", {data_addr_ok, awvalid, wvalid, bready, data_data_ok},
               {(k == 0 || k == 6), (k == 1), (k >= 1 && k <= 3), (k == 4 || k == 5), (k == 5)});
      if (k == 1) check_eq("t4_aw", {awsize, awaddr}, {3'd1, 32'h8000});
      if (k == 3) check_eq("t4_w", {wstrb, wdata}, {4'h3, 32'h0000_BEEF});
      nxt();
    end

    // Reset during W_SEND with a read also in flight
    data_req = 0; awready = 0; wready = 0; bvalid = 0;
    inst_req = 1; inst_addr = 32'h4000;
    smp();
    check_eq("t6_wsend", {awvalid, wvalid}, 2'b11);
    check_eq("t6_inst_acc", inst_addr_ok, 1);
    nxt(); inst_req = 0; rst = 1;
    nxt();
    smp();
    check_eq("t6_rst", {arvalid, awvalid, wvalid, bready, rready, data_data_ok, inst_data_ok}, '0);
    nxt(); rst = 0;
    data_req = 1; data_wr = 1; data_addr = 32'h9000; data_size = 2'd2;
    data_wstrb = 4'hF; data_wdata = 32'h1357_9BDF;
    inst_req = 1; inst_addr = 32'h5000;
    smp(); check_eq("t6_fresh", {inst_addr_ok, data_addr_ok}, 2'b11);

    // Randomized traffic
    nxt(); rst = 1; idle_inputs();
    repeat (3) nxt();
    rst = 0;
    repeat (2) nxt();
    inst_q.delete(); data_q.delete(); ar_q.delete(); slv_r.delete();
    aw_got = 0; w_got = 0; pb_v = 0; pb_id = '0;

    for (int c = 0; c < 3000; c++) begin
      smp();
      ar_free    = (ar_q.size() == 0);
      d_free     = (data_q.size() == 0);
      wr_act     = !d_free && data_q[0].wr;
      e_rwin     = data_req && !data_wr && d_free && ar_free;
      e_inst_aok = inst_req && ar_free && (inst_q.size() == 0) && !e_rwin;
      e_data_aok = e_rwin || (data_req && data_wr && d_free);
      e_awvalid  = wr_act && !aw_got;
      e_wvalid   = wr_act && !w_got;
      e_bready   = aw_got && w_got;
      eb_v       = (RL == 1) ? pb_v : rvalid;
      eb_id      = (RL == 1) ? pb_id : rid;
      e_inst_ok  = eb_v && eb_id == 4'd0 && inst_q.size() != 0;
      e_data_rok = eb_v && eb_id == 4'd1 && !d_free && !data_q[0].wr;
      e_b_ok     = bvalid && aw_got && w_got;

      check_eq("rready", rready, 1);
      check_eq("inst_addr_ok", inst_addr_ok, e_inst_aok);
      check_eq("data_addr_ok", data_addr_ok, e_data_aok);
      check_eq("arvalid", arvalid, !ar_free);
      if (arvalid && !ar_free)
        check_eq("ar_fields", {arid, arsize, araddr}, {ar_q[0].id, ar_q[0].size, ar_q[0].addr});
      check_eq("awvalid", awvalid, e_awvalid);
      if (awvalid && e_awvalid)
        check_eq("aw_fields", {awsize, awaddr}, {1'b0, data_q[0].size, data_q[0].addr});
      check_eq("wvalid", wvalid, e_wvalid);
      if (wvalid && e_wvalid)
        check_eq("w_fields", {wstrb, wdata}, {data_q[0].strb, data_q[0].wdata});
      check_eq("bready", bready, e_bready);
      check_eq("inst_data_ok", inst_data_ok, e_inst_ok);
      if (inst_data_ok && e_inst_ok)
        check_eq("inst_rdata", inst_rdata, mem_f(inst_q[0]));
      check_eq("data_data_ok", data_data_ok, e_data_rok || e_b_ok);
      if (data_data_ok && e_data_rok)
        check_eq("data_rdata", data_rdata, mem_f(data_q[0].addr));

      if (arvalid && arready && !ar_free) begin
        slv_r.push_back(ar_q[0]);
        ar_q.pop_front();
      end
      if (awvalid && awready) aw_got = 1;
      if (wvalid && wready) w_got = 1;
      if (e_b_ok) begin aw_got = 0; w_got = 0; end
      if (e_inst_ok) void'(inst_q.pop_front());
      if (e_data_rok || e_b_ok) void'(data_q.pop_front());
      if (e_inst_aok) begin
        inst_q.push_back(inst_addr);
        ar_q.push_back(arx_t'{4'd0, 3'd2, inst_addr});
      end
      if (e_data_aok) begin
        data_q.push_back(dreq_t'{data_wr, data_size, data_wstrb, data_addr, data_wdata});
        if (!data_wr) ar_q.push_back(arx_t'{4'd1, {1'b0, data_size}, data_addr});
      end
      pb_v = rvalid; pb_id = rid;

      nxt();
      arready = ($urandom_range(0, 3) != 0);
      awready = ($urandom_range(0, 2) != 0);
      wready  = ($urandom_range(0, 2) != 0);
      if (e_b_ok) bvalid = 0;
      else if (!bvalid && aw_got && w_got) bvalid = ($urandom_range(0, 1) == 1);
      if (slv_r.size() != 0 && $urandom_range(0, 2) == 0) begin
        idx = $urandom_range(0, slv_r.size() - 1);
        rvalid = 1; rid = slv_r[idx].id; rdata = mem_f(slv_r[idx].addr);
        slv_r.delete(idx);
      end else if ($urandom_range(0, 15) == 0) begin
        rvalid = 1; rid = 4'd7; rdata = $urandom;
      end else begin
        rvalid = 0; rid = 4'($urandom); rdata = $urandom;
      end
      if (!inst_req || e_inst_aok) begin
        inst_req  = ($urandom_range(0, 2) != 0);
        inst_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!data_req || e_data_aok) begin
        data_req   = ($urandom_range(0, 2) != 0);
        data_wr    = $urandom_range(0, 1);
        data_size  = 2'($urandom_range(0, 2));
        data_addr  = $urandom;
        data_wstrb = 4'($urandom);
        data_wdata = $urandom;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_axi_bridge.md
# cpu_axi_bridge

Converts the core's two SRAM-like request/response ports (instruction fetch, data access) into a single AXI3 master. Sits directly downstream of `mycpu_top`, between the core's `inst_sram_*`/`data_sram_*` side and the system AXI crossbar. It arbitrates the shared AR channel, runs an AW/W/B write sequencer, and routes R responses back by ID.

## Interface
Parameters:
- none

Ports (`name direction width meaning`):
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `inst_req` in 1: fetch request, always a 4-byte read.
- `inst_addr` in 32: fetch address.
- `inst_addr_ok` out 1: fetch request accepted this cycle.
- `inst_data_ok` out 1: fetch data valid.
- `inst_rdata` out 32: fetch data.
- `data_req` in 1: data request.
- `data_wr` in 1: 1 = write, 0 = read.
- `data_size` in 2: 0 = byte, 1 = half, 2 = word.
- `data_wstrb` in 4: write byte strobes.
- `data_addr` in 32: data address.
- `data_wdata` in 32: write data.
- `data_addr_ok` out 1: data request accepted.
- `data_data_ok` out 1: read data valid, or write completed.
- `data_rdata` out 32: read data.
- `arid` out 4: 0 = inst, 1 = data.
- `araddr` out 32, `arsize` out 3, `arvalid` out 1, `arready` in 1: AR channel.
- `rid` in 4, `rdata` in 32, `rvalid` in 1, `rready` out 1: R channel.
- `awaddr` out 32, `awsize` out 3, `awvalid` out 1, `awready` in 1: AW channel.
- `wdata` out 32, `wstrb` out 4, `wvalid` out 1, `wready` in 1: W channel.
- `bvalid` in 1, `bready` out 1: B channel.

Constant AXI fields are tied at the top level, not in this block: `len` = 0, `burst` = INCR, `lock`/`cache`/`prot` = 0, `awid`/`wid` = 1.

## Operation
- **Outstanding limits:** each source has at most one transaction outstanding. Flags `inst_pend` and `data_pend` set on the addr_ok cycle and clear on the matching data_ok cycle.
- **Read accept:**
  - `inst_addr_ok = inst_req & ar_idle & ~inst_pend & ~data_rd_win`.
  - `data_rd_win = data_req & ~data_wr & ~data_pend & ar_idle`; its value is `data_addr_ok` for reads.
  - On a same-cycle tie, data wins.
- **AR FSM:**
  - AR_IDLE, then on accept go to AR_SEND. Capture addr/size/id there; `arsize = {1'b0,size}`, inst size = 2.
  - Hold `arvalid` with stable fields until `arready`, then return to AR_IDLE.
  - A new accept is possible on the cycle after the return.
- **R routing:**
  - `rready` = 1 whenever not in reset.
  - An `rvalid` whose `rid` matches a pending source completes that source.
  - An `rvalid` with an unmatched `rid` is consumed and ignored.
- **Write accept:** `data_addr_ok = data_req & data_wr & w_idle & ~data_pend`.
- **W FSM:**
  - W_IDLE, then on accept go to W_SEND. `awvalid` and `wvalid` rise together and each drops independently on its own handshake.
  - When both are done, go to W_RESP with `bready` = 1.
  - On `bvalid`, pulse `data_data_ok` and return to W_IDLE.
- `bready` is 0 outside W_RESP.
- `data_rdata` is don't-care on a write completion.

## Timing
- **Reset values:** all `*_addr_ok`, `*_data_ok`, `arvalid`, `awvalid`, `wvalid`, `bready` = 0; `rready` = 0; FSMs idle; pend flags 0; rdata outputs 0.
- **Reset mid-transaction** abandons all in-flight AXI transfers. The slave shares `rst`.
- **Minimum read latency:**
  - cycle 0: req & addr_ok.
  - cycle 1: arvalid with arready.
  - cycle 2: rvalid.
  - `data_ok` on cycle 2 (unbuffered) or cycle 3 (buffered; see Configuration).
- **Minimum write latency:** accept at cycle 0; AW/W handshakes at cycle 1; `bvalid` and `data_data_ok` at cycle 2.
- `addr_ok` is combinational from req and state; `data_ok` is a single-cycle pulse.
- AR/AW/W payloads never change while their valid is high.

## Configuration
- **`AXI_BRIDGE_RDATA_BUF_EN` defined:**
  - R data and id are registered.
  - `*_data_ok`/`*_rdata` come from registers, one cycle after the `rvalid` handshake.
  - The pend flag clears on the registered pulse.
- **Undefined:** `inst_data_ok = rvalid & rid==0 & inst_pend` (likewise `data_data_ok` for data reads, with `rid==1`), and `*_rdata = rdata`, all combinational.
- Write completion timing is the same in both builds.

## Test plan
- **Single fetch:** `inst_req` at 0x1C000000; slave arready=1 immediately and returns rdata 0x02800C0C one cycle later. Required: arid=0, arsize=2; `inst_data_ok` with 0x02800C0C at cycle 2 (cycle 3 if BUF_EN).
- **Simultaneous reads:** inst@0x100 and data read@0x200 (size 0) in the same cycle. Required: data is accepted first with arid=1, arsize=0; inst is accepted the cycle after AR returns to idle.
- **Out-of-order R:** the data response (rid=1, 0xAAAA5555) returns before the inst response (rid=0, 0x12345678). Required: each arrives only on its own data_ok with the correct value.
- **Write with skewed handshakes:** `data_wr`, addr 0x8000, wstrb 0x3, wdata 0xBEEF. Slave awready at cycle 1, wready at cycle 3, bvalid at cycle 5. Required: wvalid stays high through cycle 3; `bready` is high only in W_RESP; `data_data_ok` pulses at cycle 5; no second data accept before cycle 6.
- **Back-pressure:** arready held low for 4 cycles. Required: `arvalid` and `araddr` stable throughout; `inst_addr_ok` stays 0 during the stall.
- **Reset mid-write:** assert `rst` during W_SEND. Required: next cycle all valids, `bready`, `rready` = 0 and pend flags cleared; a fresh request is accepted after reset deasserts.
